// File: rtl/vga_text_timing.sv
// Parametrised VGA raster and text-mode timing generator.
// Coordinates/indices are stage-0; sync, valid and colour trail them by PIPE cycles.
module vga_text_timing #(
    parameter int H_ACTIVE     = 640,
    parameter int H_FP         = 16,
    parameter int H_SYNC       = 96,
    parameter int H_BP         = 48,
    parameter int V_ACTIVE     = 480,
    parameter int V_FP         = 10,
    parameter int V_SYNC       = 2,
    parameter int V_BP         = 33,
    parameter int HSYNC_POL    = 0,
    parameter int VSYNC_POL    = 0,
    parameter int CHAR_W       = 9,
    parameter int CHAR_H       = 16,
    parameter int COLS         = 70,
    parameter int ROWS         = 30,
    parameter int PIPE         = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [23:0] vga_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic [7:0]  char_col,
    output logic [7:0]  char_row,
    output logic [3:0]  glyph_x,
    output logic [3:0]  glyph_y,
    output logic        text_valid,
    output logic        line_start,
    output logic        frame_start,
    output logic        blink,
    output logic        hsync,
    output logic        vsync,
    output logic        valid,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  HS_FIRST   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_LAST    = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST    = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0]  TEXT_W     = 10'(COLS * CHAR_W);
    localparam logic [9:0]  TEXT_H     = 10'(ROWS * CHAR_H);
    localparam logic [3:0]  GX_LAST    = 4'(CHAR_W - 1);
    localparam logic [3:0]  GY_LAST    = 4'(CHAR_H - 1);
    localparam logic [15:0] BLINK_LAST = 16'(BLINK_FRAMES - 1);
    localparam logic        HS_ON      = 1'(HSYNC_POL);
    localparam logic        VS_ON      = 1'(VSYNC_POL);

    logic [9:0]  r_x_cnt;
    logic [9:0]  r_y_cnt;
    logic [3:0]  r_glyph_x;
    logic [7:0]  r_char_col;
    logic [3:0]  r_glyph_y;
    logic [7:0]  r_char_row;
    logic [15:0] r_frame_cnt;
    logic        r_blink;

    logic        w_x_last;
    logic        w_y_last;
    logic [9:0]  w_x_next;
    logic [9:0]  w_y_next;
    logic        w_h_act;
    logic        w_v_act;
    logic        w_x_text_next;
    logic        w_y_text_next;
    logic        w_act0;
    logic        w_hs0;
    logic        w_vs0;
    logic [2:0]  w_stage0;
    logic [2:0]  w_dly;

    assign w_x_last = (r_x_cnt == H_LAST);
    assign w_y_last = (r_y_cnt == V_LAST);
    assign w_x_next = w_x_last ? 10'd0 : r_x_cnt + 10'd1;
    assign w_y_next = w_y_last ? 10'd0 : r_y_cnt + 10'd1;
    assign w_h_act  = (r_x_cnt < H_ACT);
    assign w_v_act  = (r_y_cnt < V_ACT);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_x_cnt <= 10'd0;
            r_y_cnt <= 10'd0;
        end else begin
            r_x_cnt <= w_x_next;
            if (w_x_last) begin
                r_y_cnt <= w_y_next;
            end
        end
    end

    // Index counters are loaded with the value belonging to the next pixel/line,
    // so they line up with x_cnt/y_cnt in the same cycle without any division.
    assign w_x_text_next = !w_x_last && (w_x_next < TEXT_W);
    assign w_y_text_next = !w_y_last && (w_y_next < TEXT_H);

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_glyph_x  <= 4'd0;
            r_char_col <= 8'd0;
        end else if (!w_x_text_next) begin
            r_glyph_x  <= 4'd0;
            r_char_col <= 8'd0;
        end else if (r_glyph_x == GX_LAST) begin
            r_glyph_x  <= 4'd0;
            r_char_col <= r_char_col + 8'd1;
        end else begin
            r_glyph_x  <= r_glyph_x + 4'd1;
        end
    end

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_glyph_y  <= 4'd0;
            r_char_row <= 8'd0;
        end else if (w_x_last) begin
            if (!w_y_text_next) begin
                r_glyph_y  <= 4'd0;
                r_char_row <= 8'd0;
            end else if (r_glyph_y == GY_LAST) begin
                r_glyph_y  <= 4'd0;
                r_char_row <= r_char_row + 8'd1;
            end else begin
                r_glyph_y  <= r_glyph_y + 4'd1;
            end
        end
    end

    assign h_addr   = w_h_act ? r_x_cnt : 10'd0;
    assign v_addr   = w_v_act ? r_y_cnt : 10'd0;
    assign glyph_x  = w_v_act ? r_glyph_x : 4'd0;
    assign char_col = w_v_act ? r_char_col : 8'd0;
    assign glyph_y  = r_glyph_y;
    assign char_row = r_char_row;

    // Stage-0 strobes are gated by reset so a PIPE=0 build still shows idle outputs.
    assign w_act0      = !reset && w_h_act && w_v_act;
    assign w_hs0       = !reset && (r_x_cnt >= HS_FIRST) && (r_x_cnt <= HS_LAST);
    assign w_vs0       = !reset && (r_y_cnt >= VS_FIRST) && (r_y_cnt <= VS_LAST);
    assign w_stage0    = {w_act0, w_hs0, w_vs0};
    assign text_valid  = w_act0 && (r_x_cnt < TEXT_W) && (r_y_cnt < TEXT_H);
    assign line_start  = !reset && (r_x_cnt == 10'd0) && w_v_act;
    assign frame_start = !reset && (r_x_cnt == 10'd0) && (r_y_cnt == 10'd0);

    generate
        if (PIPE == 0) begin : g_no_pipe
            assign w_dly = w_stage0;
        end else begin : g_pipe
            logic [2:0] r_dl [PIPE];
            always_ff @(posedge pclk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < PIPE; i++) begin
                        r_dl[i] <= 3'b000;
                    end
                end else begin
                    r_dl[0] <= w_stage0;
                    for (int i = 1; i < PIPE; i++) begin
                        r_dl[i] <= r_dl[i-1];
                    end
                end
            end
            assign w_dly = r_dl[PIPE-1];
        end
    endgenerate

    assign valid = w_dly[2];
    assign hsync = w_dly[1] ? HS_ON : ~HS_ON;
    assign vsync = w_dly[0] ? VS_ON : ~VS_ON;
    assign vga_r = valid ? vga_data[23:16] : 8'd0;
    assign vga_g = valid ? vga_data[15:8]  : 8'd0;
    assign vga_b = valid ? vga_data[7:0]   : 8'd0;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= 16'd0;
            r_blink     <= 1'b0;
        end else if (frame_start) begin
            if (r_frame_cnt == BLINK_LAST) begin
                r_frame_cnt <= 16'd0;
                r_blink     <= ~r_blink;
            end else begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign blink = r_blink;

endmodule

// File: tb/tb_vga_text_timing.sv
// Directed bench for vga_text_timing: default 800-cycle lines, a short 38-line frame
// so several frames fit the cycle budget; text area is 70x2 cells of 9x16.
module tb_vga_text_timing;

  localparam int LINE  = 800;
  localparam int FRAME = LINE * 38;

  logic        pclk = 1'b0;
  logic        reset;
  logic [23:0] vga_data;
  logic [9:0]  h_addr;
  logic [9:0]  v_addr;
  logic [7:0]  char_col;
  logic [7:0]  char_row;
  logic [3:0]  glyph_x;
  logic [3:0]  glyph_y;
  logic        text_valid;
  logic        line_start;
  logic        frame_start;
  logic        blink;
  logic        hsync;
  logic        vsync;
  logic        valid;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  vga_text_timing #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .HSYNC_POL(0), .VSYNC_POL(0),
    .CHAR_W(9), .CHAR_H(16), .COLS(70), .ROWS(2),
    .PIPE(2), .BLINK_FRAMES(2)
  ) dut (
    .pclk(pclk), .reset(reset), .vga_data(vga_data),
    .h_addr(h_addr), .v_addr(v_addr),
    .char_col(char_col), .char_row(char_row),
    .glyph_x(glyph_x), .glyph_y(glyph_y),
    .text_valid(text_valid), .line_start(line_start), .frame_start(frame_start),
    .blink(blink), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  // clock / reset
  always #5 pclk = ~pclk;

  // cycle k after release = x (k mod 800), y ((k/800) mod 38); sampled 1 unit after the edge
  task automatic goto(input int k);
    while (cyc < k) begin
      @(posedge pclk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b1;
    vga_data = 24'hFF8040;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("rst_frame_start", 32'(frame_start), 32'd0);
    chk("rst_line_start", 32'(line_start), 32'd0);

    @(negedge pclk);
    reset = 1'b0;
    #1;
    cyc = 0;
    chk("c0_frame_start", 32'(frame_start), 32'd1);
    chk("c0_line_start", 32'(line_start), 32'd1);
    chk("c0_h_addr", 32'(h_addr), 32'd0);
    chk("c0_char_col", 32'(char_col), 32'd0);
    chk("c0_valid", 32'(valid), 32'd0);
    chk("c0_text_valid", 32'(text_valid), 32'd1);

    goto(1);
    chk("x1_valid", 32'(valid), 32'd0);
    chk("x1_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("x1_frame_start", 32'(frame_start), 32'd0);
    goto(2);
    chk("x2_valid", 32'(valid), 32'd1);
    chk("x2_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h00FF8040);

    goto(8);
    chk("x8_col", 32'(char_col), 32'd0);
    chk("x8_gx", 32'(glyph_x), 32'd8);
    goto(9);
    chk("x9_col", 32'(char_col), 32'd1);
    chk("x9_gx", 32'(glyph_x), 32'd0);
    goto(629);
    chk("x629_col", 32'(char_col), 32'd69);
    chk("x629_gx", 32'(glyph_x), 32'd8);
    chk("x629_tv", 32'(text_valid), 32'd1);
    goto(630);
    chk("x630_h_addr", 32'(h_addr), 32'd630);
    chk("x630_tv", 32'(text_valid), 32'd0);
    chk("x630_col", 32'(char_col), 32'd0);
    chk("x630_gx", 32'(glyph_x), 32'd0);
    // colour at x=641 belongs to pixel 639, the last active one
    goto(641);
    chk("x641_valid", 32'(valid), 32'd1);
    goto(642);
    chk("x642_valid", 32'(valid), 32'd0);
    chk("x642_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    goto(650);
    chk("x650_h_addr", 32'(h_addr), 32'd0);
    goto(657);
    chk("x657_hsync", 32'(hsync), 32'd1);
    goto(658);
    chk("x658_hsync", 32'(hsync), 32'd0);
    goto(753);
    chk("x753_hsync", 32'(hsync), 32'd0);
    goto(754);
    chk("x754_hsync", 32'(hsync), 32'd1);

    goto(LINE);
    chk("y1_line_start", 32'(line_start), 32'd1);
    chk("y1_v_addr", 32'(v_addr), 32'd1);
    chk("y1_frame_start", 32'(frame_start), 32'd0);
    goto(LINE + 1);
    chk("y1_line_start_end", 32'(line_start), 32'd0);
    vga_data = 24'h123456;
    goto(LINE + 105);
    chk("y1_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'h00123456);
    vga_data = 24'hFF8040;

    goto(15 * LINE + 5);
    chk("y15_v_addr", 32'(v_addr), 32'd15);
    chk("y15_row", 32'(char_row), 32'd0);
    chk("y15_gy", 32'(glyph_y), 32'd15);
    goto(16 * LINE + 5);
    chk("y16_row", 32'(char_row), 32'd1);
    chk("y16_gy", 32'(glyph_y), 32'd0);
    chk("y16_gx", 32'(glyph_x), 32'd5);
    goto(31 * LINE + 5);
    chk("y31_v_addr", 32'(v_addr), 32'd31);
    chk("y31_row", 32'(char_row), 32'd1);
    chk("y31_gy", 32'(glyph_y), 32'd15);

    goto(32 * LINE);
    chk("y32_line_start", 32'(line_start), 32'd0);
    chk("y32_v_addr", 32'(v_addr), 32'd0);
    goto(32 * LINE + 20);
    chk("y32_h_addr", 32'(h_addr), 32'd20);
    chk("y32_col", 32'(char_col), 32'd0);
    chk("y32_row", 32'(char_row), 32'd0);
    chk("y32_tv", 32'(text_valid), 32'd0);
    chk("y32_valid", 32'(valid), 32'd0);

    goto(34 * LINE + 1);
    chk("vs_before", 32'(vsync), 32'd1);
    goto(34 * LINE + 2);
    chk("vs_fall", 32'(vsync), 32'd0);
    goto(36 * LINE + 1);
    chk("vs_last", 32'(vsync), 32'd0);
    goto(36 * LINE + 2);
    chk("vs_rise", 32'(vsync), 32'd1);

    goto(FRAME - 1);
    chk("f1_pre_frame_start", 32'(frame_start), 32'd0);
    goto(FRAME);
    chk("f1_frame_start", 32'(frame_start), 32'd1);
    chk("f1_blink_pre", 32'(blink), 32'd0);
    goto(FRAME + 1);
    chk("f1_blink_toggled", 32'(blink), 32'd1);
    chk("f1_frame_start_end", 32'(frame_start), 32'd0);
    goto(2 * FRAME);
    chk("f2_frame_start", 32'(frame_start), 32'd1);
    goto(2 * FRAME + 1);
    chk("f2_blink_hold", 32'(blink), 32'd1);

    goto(2 * FRAME + 700);
    chk("mid_hsync_pre", 32'(hsync), 32'd0);
    reset = 1'b1;
    #1;
    chk("mid_rst_hsync", 32'(hsync), 32'd1);
    chk("mid_rst_vsync", 32'(vsync), 32'd1);
    chk("mid_rst_valid", 32'(valid), 32'd0);
    chk("mid_rst_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
    chk("mid_rst_blink", 32'(blink), 32'd0);
    chk("mid_rst_h_addr", 32'(h_addr), 32'd0);
    chk("mid_rst_line_start", 32'(line_start), 32'd0);
    chk("mid_rst_tv", 32'(text_valid), 32'd0);

    @(negedge pclk);
    reset = 1'b0;
    #1;
    cyc = 0;
    chk("re_frame_start", 32'(frame_start), 32'd1);
    chk("re_hsync", 32'(hsync), 32'd1);
    goto(2);
    chk("re_valid", 32'(valid), 32'd1);
    goto(657);
    chk("re_x657_hsync", 32'(hsync), 32'd1);
    goto(658);
    chk("re_x658_hsync", 32'(hsync), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
